mode_sequencer: RTL
===================

# mode_sequencer

Control sequencer for the Romulus-N1 unrolled datapath (8 SKINNY-128-384+ rounds per cycle). Takes one block command, moves 32-bit words in over valid/ready handshakes, and drives the datapath's load/encrypt enables, round constants and counter correction. Also unloads the 128-bit result as four 32-bit words. The block is the initiator side of the datapath's control interface: every enable, reset and constant the datapath consumes comes from here.

## Interface
- ENC_CYCLES, 5, encrypt cycles per block (5 × 8 = 40 rounds)
- BEATS, 4, 32-bit words per 128-bit load/unload
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  block command strobe, sampled in IDLE only
- load_key  in  1  with start: 1 = run LOAD_KEY, 0 = skip it
- new_msg  in  1  with start: 1 = clear the counter (zrst) before the block
- dec  in  1  with start: block is decryption
- ad_blk  in  1  with start: associated-data block (drives tk1s)
- sdi_valid / sdi_ready  in / out  1  key word handshake
- pdi_valid / pdi_ready  in / out  1  nonce and message word handshake
- pdo_valid / pdo_ready  out / in  1  result word handshake
- srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse, erst  out  1 each  datapath register controls
- correct_cnt  out  1  selects the corrected-counter path into the counter LFSR
- tk1s  out  1  counter permutation select
- decrypt  out  4  per-byte decrypt mask
- constant … constant8  out  6 each  round constants for the 8 unrolled rounds
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, LOAD_KEY, LOAD_TKY, LOAD_S, ENC, RESTORE, OUT.
- **IDLE**
  - start=1: latch dec, ad_blk and load_key.
  - Assert zrst for that cycle if new_msg=1.
  - Go to LOAD_KEY if load_key=1, else LOAD_TKY.
- **LOAD_KEY**
  - sdi_ready=1.
  - Each accepted beat (sdi_valid & sdi_ready) asserts xse in the same cycle.
  - After BEATS beats, go to LOAD_TKY.
- **LOAD_TKY**
  - pdi_ready=1; an accepted beat asserts yse.
  - After BEATS beats, go to LOAD_S.
- **LOAD_S**
  - pdi_ready=1; an accepted beat asserts sse.
  - decrypt={4{dec}} in this state and in OUT, else 0.
  - After BEATS beats, go to ENC.
- **ENC**
  - senc=xenc=yenc=zenc=1 for ENC_CYCLES consecutive cycles.
  - A 3-bit cycle counter runs 0..ENC_CYCLES-1.
  - Round-constant register rc (6 bits) is 0 at entry. Step function: rc' = {rc[4:0], rc[5]^rc[4]^1}.
  - constant = step¹(rc) through constant8 = step⁸(rc), all combinational.
  - rc ← step⁸(rc) at the end of each ENC cycle.
  - Outside ENC, all constants are 0.
- **RESTORE**
  - One cycle: xse=yse=zse=1, correct_cnt=1, tk1s=ad_blk.
  - This reloads the reverted tweakey and the advanced counter.
- **OUT**
  - pdo_valid=1.
  - Each accepted beat (pdo_valid & pdo_ready) asserts sse to shift the next word out.
  - After BEATS beats: go to IDLE, pulse done, clear rc.
- Only one se/enc group is active per cycle, except in ENC and RESTORE as listed above.
- erst, srst, xrst and yrst are asserted for the single cycle after reset deassertion (INIT pulse), else 0.
- start outside IDLE is ignored.

## Timing
- Reset (rst_n=0):
  - State goes to IDLE; rc, beat counter and cycle counter go to 0.
  - Every output is 0, including ready/valid, enables and constants.
  - The same applies when rst_n falls mid-block.
- The first cycle after rst_n rises asserts the INIT pulse. start is ignored in that cycle.
- Handshakes:
  - Ready/valid outputs are registered-state decodes, with no combinational path from valid to ready.
  - A stalled valid input holds the state and beat counter.
  - pdo_valid stays high until pdo_ready.
- Beat counter is 2 bits and wraps 3→0 on the last beat, which also changes state.
- Minimum block latency with no stalls and load_key=1:
  - 1 (start) + 4 + 4 + 4 + 5 + 1 + 4 = 23 cycles from start to done.
  - With load_key=0: 19 cycles.
- After ENC_CYCLES cycles, rc equals round constant 40.

## Structure
- Package mode_seq_pkg: state enum, ENC_CYCLES, BEATS, RC_INIT=6'h00, and the rc step function.
- Sub-module rc_lfsr8: 6-bit register plus 8-step combinational unroll, outputs constant…constant8.
- FSM, beat counter and cycle counter live in mode_sequencer.

## Test plan
- Reset then start, load_key=1, all valids/readys held high:
  - INIT pulse one cycle after reset release.
  - done 23 cycles after start.
  - xse/yse/sse each high exactly 4 cycles in their states.
- First ENC cycle constants = 01,03,07,0F,1F,3E,3D,3B; second cycle constant = 37, constant2 = 2F.
- load_key=0: sdi_ready never asserts and done arrives at 19 cycles.
- pdi_valid dropped for 3 cycles in beat 2 of LOAD_S:
  - sse is low during the gap.
  - State holds and exactly 4 sse pulses occur.
- pdo_ready low for 5 cycles in OUT: pdo_valid held, sse low, beat count unchanged.
- rst_n pulsed low in ENC cycle 3: all outputs 0 immediately. A new block then restarts with constant = 01.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// rtl/mode_seq_pkg.sv - shared constants, state codes and round-constant step for mode_sequencer
package mode_seq_pkg;

    localparam int ENC_CYCLES = 5;
    localparam int BEATS      = 4;

    localparam logic [5:0] RC_INIT = 6'h00;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD_KEY = 3'd1;
    localparam state_t ST_LOAD_TKY = 3'd2;
    localparam state_t ST_LOAD_S   = 3'd3;
    localparam state_t ST_ENC      = 3'd4;
    localparam state_t ST_RESTORE  = 3'd5;
    localparam state_t ST_OUT      = 3'd6;

    // One SKINNY round-constant LFSR step.
    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/rc_lfsr8.sv
// rtl/rc_lfsr8.sv - round-constant register with an 8-round combinational unroll
module rc_lfsr8
    import mode_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic       en_i,
    output logic [5:0] constant_o,
    output logic [5:0] constant2_o,
    output logic [5:0] constant3_o,
    output logic [5:0] constant4_o,
    output logic [5:0] constant5_o,
    output logic [5:0] constant6_o,
    output logic [5:0] constant7_o,
    output logic [5:0] constant8_o
);

    logic [5:0] rc_q, rc_d;
    logic [5:0] chain [0:8];

    always_comb begin
        chain[0] = rc_q;
        for (int i = 1; i <= 8; i++) begin
            chain[i] = rc_step(chain[i-1]);
        end
    end

    always_comb begin
        rc_d = rc_q;
        if (clr_i) begin
            rc_d = RC_INIT;
        end else if (adv_i) begin
            rc_d = chain[8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rc_q <= RC_INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

    // The datapath only consumes constants while encrypting; hold them at zero otherwise.
    assign constant_o  = en_i ? chain[1] : 6'h00;
    assign constant2_o = en_i ? chain[2] : 6'h00;
    assign constant3_o = en_i ? chain[3] : 6'h00;
    assign constant4_o = en_i ? chain[4] : 6'h00;
    assign constant5_o = en_i ? chain[5] : 6'h00;
    assign constant6_o = en_i ? chain[6] : 6'h00;
    assign constant7_o = en_i ? chain[7] : 6'h00;
    assign constant8_o = en_i ? chain[8] : 6'h00;

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - block-level control sequencer for the unrolled Romulus-N1 datapath
module mode_sequencer
    import mode_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       load_key_i,
    input  logic       new_msg_i,
    input  logic       dec_i,
    input  logic       ad_blk_i,
    input  logic       sdi_valid_i,
    output logic       sdi_ready_o,
    input  logic       pdi_valid_i,
    output logic       pdi_ready_o,
    output logic       pdo_valid_o,
    input  logic       pdo_ready_i,
    output logic       srst_o,
    output logic       senc_o,
    output logic       sse_o,
    output logic       xrst_o,
    output logic       xenc_o,
    output logic       xse_o,
    output logic       yrst_o,
    output logic       yenc_o,
    output logic       yse_o,
    output logic       zrst_o,
    output logic       zenc_o,
    output logic       zse_o,
    output logic       erst_o,
    output logic       correct_cnt_o,
    output logic       tk1s_o,
    output logic [3:0] decrypt_o,
    output logic [5:0] constant_o,
    output logic [5:0] constant2_o,
    output logic [5:0] constant3_o,
    output logic [5:0] constant4_o,
    output logic [5:0] constant5_o,
    output logic [5:0] constant6_o,
    output logic [5:0] constant7_o,
    output logic [5:0] constant8_o,
    output logic       busy_o,
    output logic       done_o
);

    state_t     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic [2:0] cyc_q, cyc_d;
    logic       dec_q, dec_d;
    logic       ad_q, ad_d;
    logic       done_q, done_d;
    logic       alive_q, init_done_q;

    logic init_pulse, start_ok, beat_acc, last_beat, last_cyc;
    logic in_key, in_tky, in_s, in_enc, in_restore, in_out;
    logic rc_clr;

    assign in_key     = (state_q == ST_LOAD_KEY);
    assign in_tky     = (state_q == ST_LOAD_TKY);
    assign in_s       = (state_q == ST_LOAD_S);
    assign in_enc     = (state_q == ST_ENC);
    assign in_restore = (state_q == ST_RESTORE);
    assign in_out     = (state_q == ST_OUT);

    // INIT is the cycle after the first clock edge out of reset; start waits until it has passed.
    assign init_pulse = alive_q & ~init_done_q;
    assign start_ok   = (state_q == ST_IDLE) & start_i & init_done_q;
    assign last_beat  = (beat_q == 2'(BEATS - 1));
    assign last_cyc   = (cyc_q == 3'(ENC_CYCLES - 1));

    always_comb begin
        beat_acc = 1'b0;
        case (state_q)
            ST_LOAD_KEY:          beat_acc = sdi_valid_i;
            ST_LOAD_TKY, ST_LOAD_S: beat_acc = pdi_valid_i;
            ST_OUT:               beat_acc = pdo_ready_i;
            default:              beat_acc = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        dec_d   = dec_q;
        ad_d    = ad_q;
        done_d  = 1'b0;
        rc_clr  = 1'b0;
        if (beat_acc) begin
            beat_d = beat_q + 2'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    dec_d   = dec_i;
                    ad_d    = ad_blk_i;
                    state_d = load_key_i ? ST_LOAD_KEY : ST_LOAD_TKY;
                end
            end
            ST_LOAD_KEY: begin
                if (beat_acc && last_beat) state_d = ST_LOAD_TKY;
            end
            ST_LOAD_TKY: begin
                if (beat_acc && last_beat) state_d = ST_LOAD_S;
            end
            ST_LOAD_S: begin
                if (beat_acc && last_beat) state_d = ST_ENC;
            end
            ST_ENC: begin
                cyc_d = last_cyc ? 3'd0 : cyc_q + 3'd1;
                if (last_cyc) state_d = ST_RESTORE;
            end
            ST_RESTORE: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (beat_acc && last_beat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rc_clr  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            beat_q      <= 2'd0;
            cyc_q       <= 3'd0;
            dec_q       <= 1'b0;
            ad_q        <= 1'b0;
            done_q      <= 1'b0;
            alive_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            dec_q       <= dec_d;
            ad_q        <= ad_d;
            done_q      <= done_d;
            alive_q     <= 1'b1;
            init_done_q <= alive_q;
        end
    end

    rc_lfsr8 u_rc (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (rc_clr),
        .adv_i       (in_enc),
        .en_i        (in_enc),
        .constant_o  (constant_o),
        .constant2_o (constant2_o),
        .constant3_o (constant3_o),
        .constant4_o (constant4_o),
        .constant5_o (constant5_o),
        .constant6_o (constant6_o),
        .constant7_o (constant7_o),
        .constant8_o (constant8_o)
    );

    // Ready/valid come from state only so no valid-to-ready combinational path exists.
    assign sdi_ready_o = in_key;
    assign pdi_ready_o = in_tky | in_s;
    assign pdo_valid_o = in_out;

    assign sse_o  = (in_s & pdi_valid_i) | (in_out & pdo_ready_i);
    assign xse_o  = (in_key & sdi_valid_i) | in_restore;
    assign yse_o  = (in_tky & pdi_valid_i) | in_restore;
    assign zse_o  = in_restore;

    assign senc_o = in_enc;
    assign xenc_o = in_enc;
    assign yenc_o = in_enc;
    assign zenc_o = in_enc;

    assign erst_o = init_pulse;
    assign srst_o = init_pulse;
    assign xrst_o = init_pulse;
    assign yrst_o = init_pulse;
    assign zrst_o = start_ok & new_msg_i;

    assign correct_cnt_o = in_restore;
    assign tk1s_o        = in_restore & ad_q;
    assign decrypt_o     = (in_s | in_out) ? {4{dec_q}} : 4'h0;

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule
